bb_spi_readout: RTL

SPI mode-0 slave readout and control stage placed directly downstream of a busy-beaver Turing-machine core. It takes the core's 64-bit step `count` and `halt` flag, snapshots them atomically at chip-select assertion, and shifts a 72-bit frame to an external host. It also decodes a one-byte host command that drives a timed, active-low reset back into the core, so the host can restart a run without reconfiguring the FPGA.

---
 rtl/bb_spi_readout.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bb_spi_readout.sv
// bb_spi_readout: SPI mode-0 slave that reads out a busy-beaver core.
//
// At chip-select assertion the core's 64-bit step count and halt flag are
// captured together with a status byte, and the 72-bit frame is shifted out
// MSB first. The first byte the host clocks in is decoded as a command. If
// it matches RST_CMD, a timed active-low reset pulse is sent back into the core.
//
// Parameters:
//   SYNC_STAGES  depth of the SCLK/CS_N/MOSI synchronisers (>= 2)
//   RST_CYCLES   length of the bb_rst_n low pulse in clk cycles (1..255)
//   RST_CMD      command byte that requests a core reset
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   count, halt  core step count and halted flag (synchronous to clk)
//   spi_sclk     host SPI clock (asynchronous, <= f(clk)/8)
//   spi_cs_n     host chip select, active low (asynchronous)
//   spi_mosi     host data in (asynchronous)
//   spi_miso     data to host, driven straight from a flop, never tristated
//   bb_rst_n     active-low reset to the core
module bb_spi_readout #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 16,
  parameter logic [7:0]  RST_CMD     = 8'h52
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] count,
  input  logic        halt,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        bb_rst_n
);

  localparam logic [6:0] BIT_MAX  = 7'd72;
  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   load_frame, end_frame, sample_en, shift_en;
  logic [71:0]            shift_reg;
  logic [6:0]             bit_cnt;
  logic [6:0]             cmd_sr;      // first seven command bits; the eighth completes the byte
  logic [5:0]             frame_seq;
  logic [7:0]             pulse_cnt, pulse_next;
  logic                   rst_active, cmd_hit;
  logic [7:0]             status;

  // Synchronisers plus one history flop per line for edge detection.
  // CS is reset to the asserted level, so a host that is already mid-frame
  // when rst_n releases cannot create a false CS fall; the bus is ignored
  // until CS goes high and falls again.
  // NOTE: all state updates use non-blocking assignments, so every flop
  // samples the pre-edge value of its neighbour and the chain shifts one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // Frame FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Frame FSM: next state.
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it holding its old value (no inferred latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (cs_fall) state_next = ST_FRAME;
      ST_FRAME: if (cs_rise) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Frame FSM: outputs. A CS rise masks SCLK edges in the same cycle.
  always_comb begin
    load_frame = 1'b0;
    end_frame  = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      ST_IDLE:  load_frame = cs_fall;
      ST_FRAME: begin
        end_frame = cs_rise;
        sample_en = sclk_rise & ~cs_rise;
        shift_en  = sclk_fall & ~cs_rise;
      end
      default: ;
    endcase
  end

  assign rst_active = (pulse_cnt != 8'd0);
  assign status     = {halt, rst_active, frame_seq};
  assign cmd_hit    = sample_en && (bit_cnt == 7'd7) && ({cmd_sr, mosi_s} == RST_CMD);

  // Shift datapath. spi_miso is the top bit of the shift register, so it is
  // a flop output. Zeros fill in from the bottom, so the line reads 0 after 72 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      frame_seq <= '0;
    end else if (load_frame) begin
      shift_reg <= {status, count};
      bit_cnt   <= '0;
      cmd_sr    <= '0;
    end else if (end_frame) begin
      shift_reg <= '0;
      if (bit_cnt == BIT_MAX) frame_seq <= frame_seq + 6'd1;
    end else begin
      if (sample_en) begin
        cmd_sr <= {cmd_sr[5:0], mosi_s};
        if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 7'd1;
      end
      if (shift_en) shift_reg <= {shift_reg[70:0], 1'b0};
    end
  end

  assign spi_miso = shift_reg[71];

  // Reset pulser. A command that arrives during a pulse reloads the counter.
  always_comb begin
    pulse_next = pulse_cnt;
    if (cmd_hit)                pulse_next = RST_LOAD;
    else if (pulse_cnt != 8'd0) pulse_next = pulse_cnt - 8'd1;
  end

  // The counter comes out of reset loaded, so each rst_n release also
  // gives the core a power-on reset. bb_rst_n is registered from the next
  // counter value, so it is low exactly while the counter is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= RST_LOAD;
      bb_rst_n  <= 1'b0;
    end else begin
      pulse_cnt <= pulse_next;
      bb_rst_n  <= (pulse_next == 8'd0);
    end
  end

endmodule
